// File: rtl/penalty_scoreboard.sv
// Penalty shootout referee: alternates A/B kicks, scores goal/save, ends early once decided,
// and plays sudden-death rounds after a regulation tie.
module penalty_scoreboard #(
  parameter int unsigned SCORE_W = 4,
  parameter int unsigned N_LONG  = 5,
  parameter int unsigned N_SHORT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               mode,
  input  logic               kick_vld,
  input  logic [2:0]         mfwd,
  input  logic [2:0]         mgk,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               turn,
  output logic [2:0]         kicks_a,
  output logic [2:0]         kicks_b,
  output logic               goal_pulse,
  output logic               save_pulse,
  output logic               sudden_death,
  output logic               game_over,
  output logic [1:0]         winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK_A, S_EVAL_A, S_KICK_B, S_EVAL_B, S_DONE
  } state_t;

  localparam int unsigned CW = SCORE_W + 4;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_a_q, score_b_q;
  logic [2:0]           kicks_a_q, kicks_b_q, n_q;
  logic                 turn_q, sd_q, goal_q, save_q, round_a_q, round_b_q;
  logic [1:0]           winner_q, dec_win;
  logic                 start_ok, kick_ok, goal, sd_enter, a_lead, b_lead, reg_end;
  logic [CW-1:0]        sa_x, sb_x, rem_a, rem_b;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign kick_ok  = kick_vld && (state_q == S_KICK_A || state_q == S_KICK_B);
  assign goal     = (mfwd >= 3'd1) && (mfwd <= 3'd5) && (mfwd != mgk);

  always_comb begin
    sa_x    = CW'(score_a_q);
    sb_x    = CW'(score_b_q);
    rem_a   = CW'(n_q) - CW'(kicks_a_q);
    rem_b   = CW'(n_q) - CW'(kicks_b_q);
    a_lead  = sa_x > (sb_x + rem_b);
    b_lead  = sb_x > (sa_x + rem_a);
    reg_end = (kicks_a_q == n_q) && (kicks_b_q == n_q);
  end

  // Sudden death starts each round level, so the round's goal flags decide it even when
  // the displayed scores have saturated.
  always_comb begin
    dec_win  = 2'b00;
    sd_enter = 1'b0;
    if (state_q == S_EVAL_A && !sd_q) begin
      if (a_lead)      dec_win = 2'b01;
      else if (b_lead) dec_win = 2'b10;
    end else if (state_q == S_EVAL_B) begin
      if (!sd_q) begin
        if (a_lead)       dec_win  = 2'b01;
        else if (b_lead)  dec_win  = 2'b10;
        else if (reg_end) sd_enter = 1'b1;
      end else if (round_a_q && !round_b_q) begin
        dec_win = 2'b01;
      end else if (!round_a_q && round_b_q) begin
        dec_win = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state_q <= S_IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_KICK_A;
      S_KICK_A:       if (kick_ok)  state_d = S_EVAL_A;
      S_EVAL_A:       state_d = (dec_win != 2'b00) ? S_DONE : S_KICK_B;
      S_KICK_B:       if (kick_ok)  state_d = S_EVAL_B;
      S_EVAL_B:       state_d = (dec_win != 2'b00) ? S_DONE : S_KICK_A;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_a_q <= '0;
      score_b_q <= '0;
      kicks_a_q <= '0;
      kicks_b_q <= '0;
      n_q       <= 3'(N_LONG);
      turn_q    <= 1'b0;
      sd_q      <= 1'b0;
      goal_q    <= 1'b0;
      save_q    <= 1'b0;
      round_a_q <= 1'b0;
      round_b_q <= 1'b0;
      winner_q  <= '0;
    end else if (!en) begin
      goal_q <= 1'b0;
      save_q <= 1'b0;
    end else begin
      goal_q <= 1'b0;
      save_q <= 1'b0;
      if (start_ok) begin
        score_a_q <= '0;
        score_b_q <= '0;
        kicks_a_q <= '0;
        kicks_b_q <= '0;
        n_q       <= mode ? 3'(N_SHORT) : 3'(N_LONG);
        turn_q    <= 1'b0;
        sd_q      <= 1'b0;
        round_a_q <= 1'b0;
        round_b_q <= 1'b0;
        winner_q  <= '0;
      end
      if (kick_ok) begin
        goal_q <= goal;
        save_q <= !goal;
        if (state_q == S_KICK_A) begin
          round_a_q <= goal;
          if (goal && score_a_q != '1)       score_a_q <= score_a_q + SCORE_W'(1);
          if (!sd_q && kicks_a_q < n_q)      kicks_a_q <= kicks_a_q + 3'd1;
        end else begin
          round_b_q <= goal;
          if (goal && score_b_q != '1)       score_b_q <= score_b_q + SCORE_W'(1);
          if (!sd_q && kicks_b_q < n_q)      kicks_b_q <= kicks_b_q + 3'd1;
        end
      end
      if (state_q == S_EVAL_A || state_q == S_EVAL_B) begin
        turn_q   <= (state_q == S_EVAL_A);
        winner_q <= dec_win;
        if (sd_enter) sd_q <= 1'b1;
      end
    end
  end

  always_comb begin
    score_a      = score_a_q;
    score_b      = score_b_q;
    turn         = turn_q;
    kicks_a      = kicks_a_q;
    kicks_b      = kicks_b_q;
    goal_pulse   = goal_q;
    save_pulse   = save_q;
    sudden_death = sd_q;
    game_over    = (state_q == S_DONE);
    winner       = winner_q;
  end

endmodule
